// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, pc_ctrl and IR field definitions for the fetch path
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with wrapping increment and jump load
// PC_REL_JMP_EN selects a pc-relative (sign-extended imm) jump instead of absolute.
module pc_reg #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            jmp,
  input  logic [7:0]      imm,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] target;

`ifdef PC_REL_JMP_EN
  assign target = pc + PC_W'($signed(imm));
`else
  assign target = PC_W'(imm);
`endif

  // Increment wraps naturally at 2^PC_W; jump and increment never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_W'(RESET_PC);
    end else if (jmp) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM, ROM latency counter and IR decode
// Jump addressing mode follows PC_REL_JMP_EN (see pc_reg).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int ROM_LAT  = 2,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_fetch,
  input  logic            en_pc,
  input  logic [1:0]      pc_ctrl,
  output logic [PC_W-1:0] rom_addr,
  output logic            rom_rd,
  input  logic [15:0]     rom_data,
  output logic            fetch_done,
  output logic [3:0]      opcode,
  output logic [1:0]      rd,
  output logic [1:0]      rs,
  output logic [7:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            busy
);

  localparam logic [1:0] CNT_INIT = 2'(ROM_LAT - 1);

  fetch_state_t state;
  logic [1:0]   cnt;
  logic [15:0]  ir;
  logic         en_fetch_q;
  logic         jmp_q;
  logic         fetch_rise;
  logic         jmp_req;
  logic         jmp_en;
  logic         inc_en;

  assign fetch_rise = en_fetch & ~en_fetch_q;
  assign jmp_req    = en_pc & (pc_ctrl == PC_JMP);
  // Edge registers track every cycle, so a request held across a fetch never fires late.
  assign jmp_en     = (state == ST_IDLE) & jmp_req & ~jmp_q;
  assign inc_en     = (state == ST_DONE) & en_pc & (pc_ctrl == PC_INC);

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_en),
    .jmp   (jmp_en),
    .imm   (imm),
    .pc    (pc)
  );

  assign rom_addr = pc;
  assign opcode   = ir[OPC_MSB:OPC_LSB];
  assign rd       = ir[RD_MSB:RD_LSB];
  assign rs       = ir[RS_MSB:RS_LSB];
  assign imm      = ir[IMM_MSB:IMM_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      ir         <= 16'd0;
      en_fetch_q <= 1'b0;
      jmp_q      <= 1'b0;
      rom_rd     <= 1'b0;
      fetch_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      en_fetch_q <= en_fetch;
      jmp_q      <= jmp_req;
      rom_rd     <= 1'b0;
      fetch_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_rise) begin
            state  <= ST_REQ;
            rom_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
          cnt   <= CNT_INIT;
        end
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            ir         <= rom_data;
            state      <= ST_DONE;
            fetch_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven bench for fetch_unit at ROM_LAT 1, 2 and 4
module tb_fetch_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_fetch = 1'b0;
  logic       en_pc = 1'b0;
  logic [1:0] pc_ctrl = 2'b00;

  logic [7:0]  rom_addr [3];
  logic        rom_rd   [3];
  logic [15:0] rom_data [3];
  logic        fetch_done [3];
  logic [3:0]  opcode [3];
  logic [1:0]  rd_f [3];
  logic [1:0]  rs_f [3];
  logic [7:0]  imm_f [3];
  logic [7:0]  pc [3];
  logic        busy [3];

  logic [15:0] mem [256];
  logic [7:0]  ap [3][4];
  logic        av [3][4];
  int          rd_cnt [3];
  int          done_cnt [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .ROM_LAT(1), .RESET_PC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en_fetch(en_fetch), .en_pc(en_pc), .pc_ctrl(pc_ctrl),
    .rom_addr(rom_addr[0]), .rom_rd(rom_rd[0]), .rom_data(rom_data[0]), .fetch_done(fetch_done[0]),
    .opcode(opcode[0]), .rd(rd_f[0]), .rs(rs_f[0]), .imm(imm_f[0]), .pc(pc[0]), .busy(busy[0]));
  fetch_unit #(.PC_W(8), .ROM_LAT(2), .RESET_PC(0)) u2 (
    .clk(clk), .rst_n(rst_n), .en_fetch(en_fetch), .en_pc(en_pc), .pc_ctrl(pc_ctrl),
    .rom_addr(rom_addr[1]), .rom_rd(rom_rd[1]), .rom_data(rom_data[1]), .fetch_done(fetch_done[1]),
    .opcode(opcode[1]), .rd(rd_f[1]), .rs(rs_f[1]), .imm(imm_f[1]), .pc(pc[1]), .busy(busy[1]));
  fetch_unit #(.PC_W(8), .ROM_LAT(4), .RESET_PC(0)) u4 (
    .clk(clk), .rst_n(rst_n), .en_fetch(en_fetch), .en_pc(en_pc), .pc_ctrl(pc_ctrl),
    .rom_addr(rom_addr[2]), .rom_rd(rom_rd[2]), .rom_data(rom_data[2]), .fetch_done(fetch_done[2]),
    .opcode(opcode[2]), .rd(rd_f[2]), .rs(rs_f[2]), .imm(imm_f[2]), .pc(pc[2]), .busy(busy[2]));

  // ROM model: data is valid only in the cycle exactly ROM_LAT after the read strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ap[k][0] <= rom_addr[k];
      av[k][0] <= rom_rd[k];
      for (int s = 1; s < 4; s++) begin
        ap[k][s] <= ap[k][s-1];
        av[k][s] <= av[k][s-1];
      end
    end
  end
  assign rom_data[0] = av[0][0] ? mem[ap[0][0]] : 16'hDEAD;
  assign rom_data[1] = av[1][1] ? mem[ap[1][1]] : 16'hDEAD;
  assign rom_data[2] = av[2][3] ? mem[ap[2][3]] : 16'hDEAD;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rom_rd[k]) rd_cnt[k] = rd_cnt[k] + 1;
      if (fetch_done[k]) done_cnt[k] = done_cnt[k] + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] jt(input logic [7:0] p, input logic [7:0] i);
`ifdef PC_REL_JMP_EN
    return p + i;
`else
    return i;
`endif
  endfunction

  // en_fetch is held high for 10 cycles, so every fetch also checks for no retrigger.
  task automatic run_fetch(input logic epc, input logic [1:0] ctl,
                           output int l0, output int l1, output int l2,
                           output logic [7:0] a1, output logic r1, output logic b1,
                           output int d_rd, output int d_done);
    int rd0, dn0;
    rd0 = rd_cnt[1];
    dn0 = done_cnt[1];
    l0 = -1; l1 = -1; l2 = -1; a1 = '0; r1 = 1'b0; b1 = 1'b0;
    en_pc = epc;
    pc_ctrl = ctl;
    en_fetch = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin
        a1 = rom_addr[1];
        r1 = rom_rd[1];
        b1 = busy[1];
      end
      if (fetch_done[0] && l0 < 0) l0 = c;
      if (fetch_done[1] && l1 < 0) l1 = c;
      if (fetch_done[2] && l2 < 0) l2 = c;
    end
    en_fetch = 1'b0;
    en_pc = 1'b0;
    pc_ctrl = PC_HOLD;
    step();
    d_rd = rd_cnt[1] - rd0;
    d_done = done_cnt[1] - dn0;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic       epc;
    logic [1:0] ctl;
    logic [3:0] op;
    logic [1:0] rdv;
    logic [1:0] rsv;
    logic [7:0] immv;
    logic [7:0] pc_after;
  } vec_t;

  vec_t vt [7];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, l2, d_rd, d_done, dn0, rd0;
    logic [7:0] a1, m_pc, m_imm, tgt;
    logic r1, b1;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h2A05;
    mem[1]   = 16'hF3C7;
    mem[2]   = 16'h1234;
    mem[3]   = 16'h8BFF;
    mem[255] = 16'h4010;
    for (int k = 0; k < 3; k++) begin
      rd_cnt[k] = 0;
      done_cnt[k] = 0;
    end

    vt[0] = '{8'h00, 1'b1, PC_INC,  4'h2, 2'd2, 2'd2, 8'h05, 8'h01};
    vt[1] = '{8'h01, 1'b1, PC_HOLD, 4'hF, 2'd0, 2'd3, 8'hC7, 8'h01};
    vt[2] = '{8'h01, 1'b1, 2'b11,   4'hF, 2'd0, 2'd3, 8'hC7, 8'h01};
    vt[3] = '{8'h01, 1'b0, PC_INC,  4'hF, 2'd0, 2'd3, 8'hC7, 8'h01};
    vt[4] = '{8'h01, 1'b1, PC_INC,  4'hF, 2'd0, 2'd3, 8'hC7, 8'h02};
    vt[5] = '{8'h02, 1'b1, PC_INC,  4'h1, 2'd0, 2'd2, 8'h34, 8'h03};
    vt[6] = '{8'h03, 1'b0, PC_INC,  4'h8, 2'd2, 2'd3, 8'hFF, 8'h03};

    step();
    step();
    chk("reset_pc", pc[1], 8'h00);
    chk("reset_rom_addr", rom_addr[1], 8'h00);
    chk("reset_rom_rd", rom_rd[1], 1'b0);
    chk("reset_fetch_done", fetch_done[1], 1'b0);
    chk("reset_busy", busy[1], 1'b0);
    chk("reset_ir", {opcode[1], rd_f[1], rs_f[1], imm_f[1]}, 16'h0000);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_fetch(vt[i].epc, vt[i].ctl, l0, l1, l2, a1, r1, b1, d_rd, d_done);
      chk($sformatf("v%0d_rom_addr", i), a1, vt[i].addr);
      chk($sformatf("v%0d_rom_rd", i), r1, 1'b1);
      chk($sformatf("v%0d_busy", i), b1, 1'b1);
      chk($sformatf("v%0d_lat1", i), l0, 3);
      chk($sformatf("v%0d_lat2", i), l1, 4);
      chk($sformatf("v%0d_lat4", i), l2, 6);
      chk($sformatf("v%0d_rd_count", i), d_rd, 1);
      chk($sformatf("v%0d_done_count", i), d_done, 1);
      chk($sformatf("v%0d_ir", i), {opcode[1], rd_f[1], rs_f[1], imm_f[1]},
          {vt[i].op, vt[i].rdv, vt[i].rsv, vt[i].immv});
      chk($sformatf("v%0d_pc", i), pc[1], vt[i].pc_after);
      chk($sformatf("v%0d_busy_idle", i), busy[1], 1'b0);
    end
    m_pc = 8'h03;
    m_imm = 8'hFF;

    // Jump edge in IDLE applies once even when the level is held.
    en_pc = 1'b1;
    pc_ctrl = PC_JMP;
    step();
    tgt = jt(m_pc, m_imm);
    chk("jump_ff", pc[1], tgt);
    step(); step(); step();
    chk("jump_held_once", pc[1], tgt);
    en_pc = 1'b0;
    pc_ctrl = PC_HOLD;
    step();
    m_pc = tgt;

    run_fetch(1'b1, PC_INC, l0, l1, l2, a1, r1, b1, d_rd, d_done);
    chk("wrap_rom_addr", a1, m_pc);
    chk("wrap_imm", imm_f[1], mem[m_pc][7:0]);
    m_imm = mem[m_pc][7:0];
    m_pc = m_pc + 8'd1;
    chk("wrap_pc", pc[1], m_pc);

    en_pc = 1'b1;
    pc_ctrl = PC_JMP;
    step();
    m_pc = jt(m_pc, m_imm);
    chk("jump_10", pc[1], m_pc);
    en_pc = 1'b0;
    pc_ctrl = PC_HOLD;
    step();

    // Jump request rising while busy is ignored, also after returning to IDLE.
    en_fetch = 1'b1;
    step();
    en_pc = 1'b1;
    pc_ctrl = PC_JMP;
    for (int c = 0; c < 8; c++) step();
    chk("jump_outside_idle", pc[1], m_pc);
    m_imm = mem[m_pc][7:0];
    en_fetch = 1'b0;
    en_pc = 1'b0;
    pc_ctrl = PC_HOLD;
    step();

    // Jump edge together with fetch edge: the fetch reads the new PC.
    en_fetch = 1'b1;
    en_pc = 1'b1;
    pc_ctrl = PC_JMP;
    step();
    m_pc = jt(m_pc, m_imm);
    chk("jump_fetch_pc", pc[1], m_pc);
    chk("jump_fetch_rd", rom_rd[1], 1'b1);
    chk("jump_fetch_addr", rom_addr[1], m_pc);
    for (int c = 0; c < 8; c++) step();
    chk("jump_fetch_ir", imm_f[1], mem[m_pc][7:0]);
    chk("jump_fetch_pc_after", pc[1], m_pc);
    en_fetch = 1'b0;
    en_pc = 1'b0;
    pc_ctrl = PC_HOLD;
    step();

    // Asynchronous reset while in WAIT aborts the fetch.
    en_pc = 1'b1;
    pc_ctrl = PC_INC;
    en_fetch = 1'b1;
    step();
    step();
    dn0 = done_cnt[1];
    rd0 = rd_cnt[1];
    #2;
    rst_n = 1'b0;
    en_fetch = 1'b0;
    #1;
    chk("abort_pc", pc[1], 8'h00);
    chk("abort_ir", {opcode[1], rd_f[1], rs_f[1], imm_f[1]}, 16'h0000);
    chk("abort_busy", busy[1], 1'b0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) step();
    chk("abort_no_done", done_cnt[1] - dn0, 0);
    chk("abort_no_rd", rd_cnt[1] - rd0, 0);
    chk("abort_pc_hold", pc[1], 8'h00);

    run_fetch(1'b1, PC_INC, l0, l1, l2, a1, r1, b1, d_rd, d_done);
    chk("resume_addr", a1, 8'h00);
    chk("resume_lat", l1, 4);
    chk("resume_ir", {opcode[1], rd_f[1], rs_f[1], imm_f[1]}, 16'h2A05);
    chk("resume_pc", pc[1], 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
